// File: rtl/pll_lock_mgr_if.sv
// PLL-side signal bundle for pll_lock_mgr: lock indicator in, PLL/system resets and status out.
// Latency: none, this is plain wiring.
// Backpressure: none; every signal is a level or a single-cycle pulse.
//
// Signals:
//   pll_locked  PLL lock indicator, asynchronous to refclk
//   pll_rst     reset request to the PLL, active-high
//   sys_rst     system reset, active-high
//   lock_ok     high while the manager is in RUN
//   lost_lock   one-cycle pulse when lock is lost from RUN
//   retry_cnt   saturating count of lock timeouts
interface pll_lock_mgr_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic       lost_lock;
    logic [7:0] retry_cnt;

    // master: the lock manager itself
    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output lock_ok,
        output lost_lock,
        output retry_cnt
    );

    // slave: the PLL / system side
    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  lock_ok,
        input  lost_lock,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_lock_mgr.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, qualifies stability, then releases sys_rst.
// Latency: sys_rst falls LOCK_STABLE_CYC+2 refclk edges after pll_locked is first sampled high.
// Backpressure: none; runs freely on refclk, all outputs registered.
//
// Ports: refclk (only clock), rst (synchronous, active-high), bus (pll_lock_mgr_if.master).
// Optional macro PLL_LOCK_DEGLITCH_EN: when defined, loss of lock in RUN requires GLITCH_CYC
// consecutive low lock samples; when undefined, a single low sample is loss of lock and
// the GLITCH_CYC parameter and its counter do not exist.
module pll_lock_mgr #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
`ifdef PLL_LOCK_DEGLITCH_EN
    parameter int GLITCH_CYC       = 4,
`endif
    parameter int CNT_W            = 17
) (
    input  logic             refclk,
    input  logic             rst,
    pll_lock_mgr_if.master   bus
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       retry_q, retry_nxt;
    logic             lost_nxt;
    logic             pll_rst_q, sys_rst_q, lock_ok_q, lost_q;
    logic             locked_m, locked_s;
    logic             lock_lost;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= bus.pll_locked;
            locked_s <= locked_m;
        end
    end

`ifdef PLL_LOCK_DEGLITCH_EN
    // Counts consecutive low lock samples while in RUN; loss is declared on the
    // sample that would bring the count to GLITCH_CYC.
    localparam int            GW          = $clog2(GLITCH_CYC + 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);

    logic [GW-1:0] glitch_cnt, glitch_nxt;

    always_comb begin
        glitch_nxt = '0;
        lock_lost  = 1'b0;
        if ((state == RUN) && !locked_s) begin
            if (glitch_cnt == GLITCH_LAST) begin
                lock_lost = 1'b1;
            end else begin
                glitch_nxt = glitch_cnt + GW'(1);
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_nxt;
        end
    end
`else
    assign lock_lost = (state == RUN) && !locked_s;
`endif

    // Next-state logic; one counter is shared by all timed states.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_q;
        lost_nxt  = 1'b0;
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABILIZE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = PLL_RESET;
                    cnt_nxt   = '0;
                    if (retry_q != 8'hFF) begin
                        retry_nxt = retry_q + 8'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABILIZE: begin
                // Any low sample restarts the whole wait, including the timeout.
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (lock_lost) begin
                    state_nxt = PLL_RESET;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = PLL_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RESET;
            cnt       <= '0;
            retry_q   <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_q   <= retry_nxt;
            pll_rst_q <= (state_nxt == PLL_RESET);
            sys_rst_q <= (state_nxt != RUN);
            lock_ok_q <= (state_nxt == RUN);
            lost_q    <= lost_nxt;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.lock_ok   = lock_ok_q;
    assign bus.lost_lock = lost_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr: directed scenarios plus random lock waveforms,
// each cycle compared against a countdown-style reference model of the sequencing rules.
// Uses a shortened lock timeout so retries and saturation fit a short run.
module tb_pll_lock_mgr;
    localparam int PRC = 16;
    localparam int TO  = 128;
    localparam int LSC = 1024;
`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int GL  = 4;
`else
    localparam int GL  = 1;
`endif

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    always #10 refclk = ~refclk;

    pll_lock_mgr_if bus();

    pll_lock_mgr #(
        .PLL_RST_CYC     (PRC),
        .LOCK_TIMEOUT_CYC(TO),
        .LOCK_STABLE_CYC (LSC),
        .CNT_W           (17)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    int    total = 0;
    int    bad   = 0;
    bit    lk_ok;
    string tname;

    // Reference model: phase name, cycles left in the phase, consecutive low samples in RUN.
    string m_phase = "RST";
    int    m_left  = PRC;
    int    m_low   = 0;
    int    m_retry = 0;
    bit    m_lost  = 0;
    bit    m_s1    = 0;
    bit    m_s2    = 0;
    int    edge_n  = 0;

    always @(posedge refclk) begin
        bit ls;
        ls = m_s2;
        edge_n++;
        m_lost = 0;
        if (rst) begin
            m_phase = "RST"; m_left = PRC; m_retry = 0; m_low = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            if (m_phase == "RST") begin
                m_left--;
                if (m_left == 0) begin m_phase = "WAIT"; m_left = TO; end
            end else if (m_phase == "WAIT") begin
                if (ls) begin
                    m_phase = "STAB"; m_left = LSC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = "RST"; m_left = PRC;
                        if (m_retry < 255) m_retry++;
                    end
                end
            end else if (m_phase == "STAB") begin
                if (!ls) begin
                    m_phase = "WAIT"; m_left = TO;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = "RUN"; m_low = 0; end
                end
            end else begin
                m_low = ls ? 0 : m_low + 1;
                if (m_low >= GL) begin
                    m_phase = "RST"; m_left = PRC; m_lost = 1; m_low = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.pll_locked;
        end
    end

    function automatic logic [11:0] exp_o();
        return {(m_phase == "RST"), (m_phase != "RUN"), (m_phase == "RUN"), m_lost, 8'(m_retry)};
    endfunction

    function automatic logic [11:0] dut_o();
        return {bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.lost_lock, bus.retry_cnt};
    endfunction

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic test_reset();
        tname = "reset";
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dut_o() !== 12'hC00) begin
                bad++;
                $display("FAIL reset_state[%0d]: got=%h want=%h", i, dut_o(), 12'hC00);
            end
        end
    endtask

    task automatic test_power_up();
        int hi, fall, e0;
        bit seen_low, done;
        tname = "power_up"; lk_ok = 1;
        rst = 1'b0;
        hi = bus.pll_rst ? 1 : 0;
        seen_low = 0; done = 0; e0 = -1; fall = -1;
        for (int c = 1; c <= 3000 && !done; c++) begin
            if (c == 100) begin bus.pll_locked = 1'b1; e0 = edge_n + 1; end
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (!seen_low) begin if (bus.pll_rst === 1'b1) hi++; else seen_low = 1; end
            if (e0 >= 0 && bus.sys_rst === 1'b0) begin fall = edge_n; done = 1; end
        end
        total++;
        if (hi != PRC) begin bad++; $display("FAIL pll_rst_width: got=%0d want=%0d", hi, PRC); end
        total++;
        if (!done || fall - e0 != LSC + 2) begin
            bad++; $display("FAIL release_latency: got=%0d want=%0d", fall - e0, LSC + 2);
        end
        total++;
        if (bus.lock_ok !== 1'b1 || bus.retry_cnt !== 8'd0) begin
            bad++; $display("FAIL run_outputs: lock_ok=%b retry=%0d want 1/0", bus.lock_ok, bus.retry_cnt);
        end
    endtask

    task automatic test_timeout();
        int prev, k;
        bit got, last;
        tname = "timeout"; lk_ok = 1;
        bus.pll_locked = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (bus.pll_rst === 1'b1) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL loss_to_reset: pll_rst=%b want 1", bus.pll_rst); end
        prev = edge_n; k = 0; last = 1;
        for (int c = 0; c < 4 * (TO + PRC) && k < 3; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (bus.pll_rst === 1'b1 && !last) begin
                k++;
                total++;
                if (edge_n - prev != TO + PRC) begin
                    bad++; $display("FAIL retry_period[%0d]: got=%0d want=%0d", k, edge_n - prev, TO + PRC);
                end
                total++;
                if (bus.retry_cnt !== 8'(k)) begin
                    bad++; $display("FAIL retry_count[%0d]: got=%0d want=%0d", k, bus.retry_cnt, k);
                end
                prev = edge_n;
            end
            last = bus.pll_rst;
        end
        total++;
        if (k != 3) begin bad++; $display("FAIL timeout_count: got=%0d want=3", k); end
    endtask

    task automatic test_saturation();
        tname = "saturation"; lk_ok = 1;
        for (int c = 0; c < 300 * (TO + PRC); c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
        end
        total++;
        if (bus.retry_cnt !== 8'd255) begin
            bad++; $display("FAIL retry_saturate: got=%0d want=255", bus.retry_cnt);
        end
        for (int c = 0; c < 2 * (TO + PRC); c++) tick();
        total++;
        if (bus.retry_cnt !== 8'd255) begin
            bad++; $display("FAIL retry_hold: got=%0d want=255", bus.retry_cnt);
        end
    endtask

    task automatic test_stab_glitch();
        int entry, er, fall;
        bit got;
        tname = "stab_glitch"; lk_ok = 1;
        rst = 1'b1; bus.pll_locked = 1'b1;
        tick();
        rst = 1'b0;
        got = 0; entry = -1;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (m_phase == "STAB") begin got = 1; entry = edge_n; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL reach_stabilize: phase=%s want STAB", m_phase); end
        for (int c = 0; c < 500; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
        end
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        er = edge_n + 1; fall = -1;
        for (int c = 0; c < 3000 && fall < 0; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (bus.sys_rst === 1'b0) fall = edge_n;
        end
        total++;
        if (fall <= entry + LSC) begin
            bad++; $display("FAIL glitch_holds_sysrst: release edge=%0d want after %0d", fall, entry + LSC);
        end
        total++;
        if (fall - er != LSC + 2) begin
            bad++; $display("FAIL glitch_release_latency: got=%0d want=%0d", fall - er, LSC + 2);
        end
    endtask

    task automatic test_run_loss();
        int len, l0, npulse, ledge, drops, exp_n;
        bit relocked;
        tname = "run_loss";
        for (int i = 0; i < 6; i++) begin
            lk_ok = 1;
            len = (i == 0) ? ((GL > 1) ? GL - 1 : 1) : (i == 1) ? GL : int'($urandom_range(1, 6));
            exp_n = (len >= GL) ? 1 : 0;
            bus.pll_locked = 1'b0;
            l0 = edge_n + 1; npulse = 0; ledge = -1; drops = 0;
            for (int c = 0; c < len + GL + 5; c++) begin
                if (c == len) bus.pll_locked = 1'b1;
                tick();
                if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                    $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
                if (bus.lock_ok !== 1'b1) drops++;
                if (bus.lost_lock === 1'b1) begin
                    npulse++; ledge = edge_n;
                    total++;
                    if ({bus.pll_rst, bus.sys_rst, bus.lock_ok} !== 3'b110) begin
                        bad++; $display("FAIL loss_outputs[%0d]: got=%b want=110", i,
                                        {bus.pll_rst, bus.sys_rst, bus.lock_ok});
                    end
                end
            end
            total++;
            if (npulse != exp_n) begin
                bad++; $display("FAIL lost_pulses[%0d] len=%0d: got=%0d want=%0d", i, len, npulse, exp_n);
            end
            if (exp_n == 1) begin
                total++;
                if (ledge != l0 + 1 + GL) begin
                    bad++; $display("FAIL lost_edge[%0d]: got=%0d want=%0d", i, ledge - l0, 1 + GL);
                end
                relocked = 0;
                for (int c = 0; c < 3000 && !relocked; c++) begin
                    tick();
                    if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                        $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
                    if (bus.lock_ok === 1'b1) relocked = 1;
                end
                total++;
                if (!relocked) begin bad++; $display("FAIL relock[%0d]: lock_ok=%b want 1", i, bus.lock_ok); end
            end else begin
                total++;
                if (drops != 0) begin
                    bad++; $display("FAIL short_glitch_ignored[%0d]: lock_ok low cycles=%0d want 0", i, drops);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int hi;
        bit got, seen_low;
        tname = "mid_reset"; lk_ok = 1;
        bus.pll_locked = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        bus.pll_locked = 1'b1;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (m_phase == "STAB") got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL mid_reach_stabilize: phase=%s want STAB", m_phase); end
        for (int c = 0; c < 700; c++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (dut_o() !== 12'hC00) begin
            bad++; $display("FAIL mid_reset_values: got=%h want=%h", dut_o(), 12'hC00);
        end
        rst = 1'b0;
        hi = bus.pll_rst ? 1 : 0; seen_low = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            if (!seen_low) begin if (bus.pll_rst === 1'b1) hi++; else seen_low = 1; end
        end
        total++;
        if (hi != PRC) begin bad++; $display("FAIL mid_pll_rst_width: got=%0d want=%0d", hi, PRC); end
    endtask

    task automatic test_random();
        int cyc, len;
        tname = "random"; lk_ok = 1;
        cyc = 0;
        while (cyc < 8000) begin
            bus.pll_locked = ($urandom_range(0, 3) != 0);
            len = bus.pll_locked ? int'($urandom_range(1, 1400)) : int'($urandom_range(1, 40));
            rst = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < len; c++) begin
                tick();
                rst = 1'b0;
                if (lk_ok) begin total++; if (dut_o() !== exp_o()) begin bad++; lk_ok = 0;
                    $display("FAIL lockstep(%s) edge=%0d dut=%h model=%h", tname, edge_n, dut_o(), exp_o()); end end
            end
            cyc += len;
        end
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        test_reset();
        test_power_up();
        test_timeout();
        test_saturation();
        test_stab_glitch();
        test_run_loss();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation time limit reached in %s", tname);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
